// File: rtl/ex_muldiv_unit_pkg.sv
// Shared encodings for the EX-stage iterative multiply/divide unit.
// The ID-stage control decoder imports the same package for the op field.
package ex_muldiv_unit_pkg;

  localparam int unsigned MD_XLEN = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } md_state_e;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one result bit per cycle on magnitudes,
// sign fix-up on the final step, registered HI/LO with a one-cycle done pulse.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs,
  input  logic [XLEN-1:0] rt,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam int unsigned AW = 2 * XLEN;

  md_state_e       r_state;
  md_state_e       w_state_nxt;
  logic [CW-1:0]   r_count;
  logic            r_is_div;
  logic            r_neg_q;
  logic            r_neg_r;
  logic            r_div0;
  logic [XLEN-1:0] r_b;
  logic [AW-1:0]   r_acc;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic            r_done;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return (~v) + XLEN'(1);
  endfunction

  function automatic logic [AW-1:0] neg_p(input logic [AW-1:0] v);
    return (~v) + AW'(1);
  endfunction

  logic            w_launch;
  logic            w_last;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_ma;
  logic [XLEN-1:0] w_mb;

  assign w_launch = (r_state == S_IDLE) && start && !flush;
  assign w_last   = (r_state == S_CALC) && (r_count == '0) && !flush;
  assign w_sa     = md_is_signed(op) & rs[XLEN-1];
  assign w_sb     = md_is_signed(op) & rt[XLEN-1];
  assign w_ma     = w_sa ? neg_x(rs) : rs;
  assign w_mb     = w_sb ? neg_x(rt) : rt;

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  logic [XLEN:0]   w_msum;
  logic [AW-1:0]   w_mul_nxt;
  assign w_msum    = {1'b0, r_acc[AW-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nxt = {w_msum, r_acc[XLEN-1:1]};

  // Restoring step: acc = {remainder, dividend/quotient}; top bit of w_sub is the borrow
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN+1:0] w_sub;
  logic            w_borrow;
  logic [AW-1:0]   w_div_nxt;
  assign w_rem_sh  = r_acc[AW-1:XLEN-1];
  assign w_sub     = {1'b0, w_rem_sh} - {2'b00, r_b};
  assign w_borrow  = w_sub[XLEN+1];
  assign w_div_nxt = {(w_borrow ? w_rem_sh[XLEN-1:0] : XLEN'(w_sub)),
                      r_acc[XLEN-2:0], ~w_borrow};

  logic [AW-1:0]   w_acc_nxt;
  logic [AW-1:0]   w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_hi_fin;
  logic [XLEN-1:0] w_lo_fin;
  assign w_acc_nxt = r_is_div ? w_div_nxt : w_mul_nxt;
  assign w_prod    = r_neg_q ? neg_p(w_acc_nxt) : w_acc_nxt;
  assign w_quo     = r_div0 ? '1
                   : (r_neg_q ? neg_x(w_acc_nxt[XLEN-1:0]) : w_acc_nxt[XLEN-1:0]);
  assign w_rem     = r_neg_r ? neg_x(w_acc_nxt[AW-1:XLEN]) : w_acc_nxt[AW-1:XLEN];
  assign w_hi_fin  = r_is_div ? w_rem : w_prod[AW-1:XLEN];
  assign w_lo_fin  = r_is_div ? w_quo : w_prod[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start && !flush) w_state_nxt = S_CALC;
      S_CALC: begin
        if (flush)                w_state_nxt = S_IDLE;
        else if (r_count == '0)   w_state_nxt = S_FIN;
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_b      <= '0;
      r_acc    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_launch) begin
        r_is_div <= md_is_div(op);
        r_neg_q  <= w_sa ^ w_sb;
        r_neg_r  <= w_sa;
        r_div0   <= (rt == '0);
        r_b      <= w_mb;
        r_acc    <= {XLEN'(0), w_ma};
        r_count  <= CW'(XLEN - 1);
      end else if (r_state == S_CALC) begin
        r_acc   <= w_acc_nxt;
        r_count <= r_count - CW'(1);
      end
      if (w_last) begin
        r_hi <= w_hi_fin;
        r_lo <= w_lo_fin;
      end
    end
  end

  // Combinational so the ID->EX register holds in the launch cycle itself
  assign stall = w_launch || (r_state == S_CALC);
  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: timeline/arithmetic reference model checked every
// cycle, plus directed vectors with hand-computed HI/LO values.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_vec;
  int n_bad;
  int cyc;

  ex_muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .flush (flush),
    .stall (stall),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Architectural result of one op, straight from integer arithmetic
  function automatic void model(input logic [1:0] o, input logic [31:0] a,
                                input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] sr;
    logic [63:0]        ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    h  = '0;
    l  = '0;
    case (o)
      2'b00: begin sr = sa * sb; h = sr[63:32]; l = sr[31:0]; end
      2'b01: begin ur = {32'd0, a} * {32'd0, b}; h = ur[63:32]; l = ur[31:0]; end
      2'b10: begin
        if (b == 32'd0) begin h = a; l = '1; end
        else begin
          sr = sa / sb; l = sr[31:0];
          sr = sa % sb; h = sr[31:0];
        end
      end
      default: begin
        if (b == 32'd0) begin h = a; l = '1; end
        else begin l = a / b; h = a % b; end
      end
    endcase
  endfunction

  // Per-cycle model: launch cycle k=0, busy k=1..33, stall k=0..32, done k=33
  logic        m_active;
  int          m_t0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic [31:0] p_hi;
  logic [31:0] p_lo;

  initial begin
    m_active = 1'b0;
    m_t0     = 0;
    m_hi     = '0;
    m_lo     = '0;
  end

  always @(negedge clk) begin
    logic e_busy;
    logic e_stall;
    logic e_done;
    int   k;
    k = 0;
    if (!rst_n) begin
      m_active = 1'b0;
      m_hi     = '0;
      m_lo     = '0;
      e_busy   = 1'b0;
      e_done   = 1'b0;
      e_stall  = start && !flush;
    end else begin
      if (!m_active && start && !flush) begin
        m_active = 1'b1;
        m_t0     = cyc;
        model(op, rs, rt, p_hi, p_lo);
      end
      k       = cyc - m_t0;
      e_busy  = m_active && (k >= 1);
      e_stall = m_active && (k <= 32);
      e_done  = m_active && (k == 33);
      if (e_done) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end
    chk("busy",  32'(busy),  32'(e_busy));
    chk("stall", 32'(stall), 32'(e_stall));
    chk("done",  32'(done),  32'(e_done));
    chk("hi",    hi, m_hi);
    chk("lo",    lo, m_lo);
    if (rst_n && m_active && (k == 33 || (k >= 1 && flush))) m_active = 1'b0;
  end

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input string nm, input bit fin_flush);
    int t0;
    bit seen;
    @(posedge clk); #1;
    op = o; rs = a; rt = b; start = 1'b1;
    t0   = cyc;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      if (!stall) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        chk({nm, "_latency"}, 32'(cyc - t0), 32'd33);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
        if (fin_flush) flush = 1'b1;
      end
    end
    if (!seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    start = 1'b0;
    if (fin_flush) begin
      @(posedge clk); #1;
      flush = 1'b0;
      chk({nm, "_fin_flush_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0;
    start = 1'b0; op = 2'b00; rs = '0; rt = '0; flush = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max", 1'b0);
    run_op(MD_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg", 1'b0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg", 1'b0);
    run_op(MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        "divu", 1'b0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div_ovf", 1'b0);
    run_op(MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_negb", 1'b0);
    run_op(MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_zero_s", 1'b0);
    run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         "mult_min", 1'b0);
    run_op(MD_MULT,  32'h1234_5678, 32'd0,         32'd0,         32'd0,         "mult_zero", 1'b1);
    run_op(MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, "divu_zero", 1'b0);

    // start and flush together in IDLE: no launch
    @(posedge clk); #1;
    op = MD_MULTU; rs = 32'd3; rt = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("start_flush_busy", 32'(busy), 32'd0);

    // flush mid-CALC: abort, prior HI/LO kept, next op runs normally
    @(posedge clk); #1;
    op = MD_MULTU; rs = 32'd11; rt = 32'd13; start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_done", 32'(done), 32'd0);
    chk("flush_hi_kept", hi, 32'd5);
    chk("flush_lo_kept", lo, 32'hFFFF_FFFF);
    run_op(MD_MULTU, 32'd9, 32'd10, 32'd0, 32'd90, "after_flush", 1'b0);

    // async reset during a DIV
    @(posedge clk); #1;
    op = MD_DIV; rs = 32'd1000; rt = 32'd3; start = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    rst_n = 1'b0; start = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(MD_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, "post_reset", 1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
